icache: RTL and testbench

- Direct-mapped instruction cache between the instruction fetcher and the memory controller's instruction-read port.
- Serves fetch hits in one cycle.
- On a miss, issues a single 32-bit word read to the memory controller and fills the line.
- Accepts a flush from the commit stage; any in-flight fill completes into the array but its result is never delivered to the fetcher.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_array.sv | 48 ++++
 rtl/icache.sv | 167 ++++++++++++++++
 tb/tb_icache.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;

    localparam int DATA_W      = 32;
    localparam int INDEX_W_DEF = 6;
    localparam int ADDR_W_DEF  = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_e;

    // Word-aligned form of a fetch address.
    function automatic logic [ADDR_W_DEF-1:0] word_align(input logic [ADDR_W_DEF-1:0] a);
        return {a[ADDR_W_DEF-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the icache: combinational read by index,
// synchronous single-port write, valid bits cleared by reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= TRUE;
        end
    end

    // NOTE: tag/data have no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, single-word fills from memory.
// Define ICACHE_PERF_EN to add hit_cnt/miss_cnt performance counters.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic              mem_rn,
    output logic [31:0]       mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_value
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    logic                drop_q, drop_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   if_inst_q, if_inst_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [INDEX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]    req_tag, fill_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                hit, complete, fill_we;
    logic                hit_evt, miss_evt;
    logic                unused_pc_bits;

    assign req_idx        = if_pc[INDEX_W+1:2];
    assign req_tag        = if_pc[ADDR_W-1:INDEX_W+2];
    assign fill_idx       = mem_addr_q[INDEX_W+1:2];
    assign fill_tag       = mem_addr_q[ADDR_W-1:INDEX_W+2];
    assign unused_pc_bits = ^if_pc[1:0];

    assign hit      = rd_valid && (rd_tag == req_tag);
    // A stale high ready on MISS entry is ignored until the controller has dropped it once.
    assign complete = (state_q == S_MISS) && armed_q && mem_ready;
    assign mem_rn   = (state_q == S_MISS) && !(armed_q && mem_ready);
    assign fill_we  = complete && rdy;

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (mem_value)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        drop_d     = drop_q;
        if_valid_d = FALSE;
        if_inst_d  = if_inst_q;
        mem_addr_d = mem_addr_q;
        hit_evt    = FALSE;
        miss_evt   = FALSE;

        case (state_q)
            S_IDLE: begin
                if (if_req && !flush) begin
                    if (hit) begin
                        if_valid_d = TRUE;
                        if_inst_d  = rd_data;
                        hit_evt    = TRUE;
                    end else begin
                        mem_addr_d = {if_pc[ADDR_W-1:2], 2'b00};
                        state_d    = S_MISS;
                        armed_d    = FALSE;
                        drop_d     = FALSE;
                        miss_evt   = TRUE;
                    end
                end
            end
            S_MISS: begin
                if (complete) begin
                    if (!(drop_q || flush)) begin
                        if_valid_d = TRUE;
                        if_inst_d  = mem_value;
                    end
                    state_d = S_IDLE;
                end else begin
                    if (flush) begin
                        drop_d = TRUE;
                    end
                    if (!armed_q && (mem_ready == LOW)) begin
                        armed_d = TRUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            armed_q    <= FALSE;
            drop_q     <= FALSE;
            if_valid_q <= FALSE;
            if_inst_q  <= '0;
            mem_addr_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign mem_addr = 32'(mem_addr_q);

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            if (hit_evt) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_evts;
    assign unused_evts = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a behavioural cache/memory model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, if_req;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        mem_rn;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_value;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .if_req    (if_req),
        .if_pc     (if_pc),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .mem_rn    (mem_rn),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_value (mem_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: backing memory image plus per-line valid/tag of a 64-line direct-mapped cache.
    logic [31:0] mem_img [logic [31:0]];
    bit          mv [64];
    logic [23:0] mt [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem_img.exists(w)) return mem_img[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return mv[pc[7:2]] && (mt[pc[7:2]] == pc[31:8]);
    endfunction

    function automatic void model_fill(input logic [31:0] pc);
        mv[pc[7:2]] = 1'b1;
        mt[pc[7:2]] = pc[31:8];
    endfunction

    typedef struct {
        logic [31:0] inst;
        bit          hit;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    int          pulse_cnt     = 0;
    bit          fill_returned = 1'b0;
    int          resp_lat      = 3;
    int          stale_hold    = 0;
    logic [31:0] exp_addr      = '0;

    // Monitor: pops the scoreboard on every delivered instruction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (if_valid === 1'b1) begin
                pulse_cnt++;
                check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("inst", if_inst, e.inst);
                    if (e.hit) begin
                        check("hit_latency", 32'(cyc - e.cyc), 32'd1);
                    end else begin
                        check("miss_filled", 32'(fill_returned), 32'd1);
                        check("miss_latency_gt1", 32'((cyc - e.cyc) > 1), 32'd1);
                    end
                end
            end
        end
    end

    // Memory controller model: optionally keeps a stale ready high, then accepts, then returns data.
    initial begin : responder
        mem_ready = 1'b1;
        mem_value = 32'h0;
        forever begin
            @(negedge clk);
            if (rst && mem_rn) begin
                fill_returned = 1'b0;
                for (int k = 0; k < stale_hold; k++) begin
                    check("stale_rn_high", 32'(mem_rn), 32'd1);
                    check("stale_no_valid", 32'(if_valid), 32'd0);
                    @(negedge clk);
                end
                check("miss_addr", mem_addr, exp_addr);
                mem_ready = 1'b0;
                for (int k = 0; k < resp_lat; k++) @(negedge clk);
                if (rst) check("miss_addr_stable", mem_addr, exp_addr);
                mem_value     = mem_word(mem_addr);
                mem_ready     = 1'b1;
                fill_returned = 1'b1;
            end
        end
    end

    task automatic prep(input logic [31:0] pc, input int lat, input int stale);
        resp_lat      = lat;
        stale_hold    = stale;
        exp_addr      = {pc[31:2], 2'b00};
        fill_returned = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input int lat, input int stale);
        exp_t e;
        int   start, t;
        prep(pc, lat, stale);
        e.inst = mem_word(pc);
        e.hit  = model_hit(pc);
        e.cyc  = cyc;
        exp_q.push_back(e);
        start  = pulse_cnt;
        if_pc  = pc;
        if_req = 1'b1;
        t = 0;
        while (pulse_cnt == start && t < 200) begin
            @(negedge clk);
            t++;
        end
        if_req = 1'b0;
        check("fetch_delivered", 32'(pulse_cnt - start), 32'd1);
        if (pulse_cnt == start) exp_q.delete();
        model_fill(pc);
    endtask

    task automatic wait_miss_issued();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_rn && t < 50);
        check("miss_issued", 32'(mem_rn), 32'd1);
    endtask

    task automatic fetch_flushed(input logic [31:0] pc, input int lat, input int d);
        int start, t;
        prep(pc, lat, 0);
        start  = pulse_cnt;
        if_pc  = pc;
        if_req = 1'b1;
        wait_miss_issued();
        if_req = 1'b0;
        repeat (d) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        t = 0;
        while (!fill_returned && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("flush_no_valid", 32'(pulse_cnt - start), 32'd0);
        check("flush_fill_done_rn", 32'(mem_rn), 32'd0);
        model_fill(pc);
    endtask

    task automatic idle_flush(input logic [31:0] pc);
        int start;
        start  = pulse_cnt;
        if_pc  = pc;
        if_req = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        if_req = 1'b0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_flush_no_valid", 32'(pulse_cnt - start), 32'd0);
        check("idle_flush_no_miss", 32'(mem_rn), 32'd0);
    endtask

    task automatic stall_fetch(input logic [31:0] pc);
        exp_t e;
        int   start, t;
        prep(pc, 4, 0);
        e.inst = mem_word(pc);
        e.hit  = model_hit(pc);
        e.cyc  = cyc;
        exp_q.push_back(e);
        start  = pulse_cnt;
        if_pc  = pc;
        if_req = 1'b1;
        wait_miss_issued();
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (6) @(negedge clk);
        check("stall_no_valid", 32'(pulse_cnt - start), 32'd0);
        check("stall_rn_from_held_state", 32'(mem_rn), 32'd0);
        rdy = 1'b1;
        t = 0;
        while (pulse_cnt == start && t < 50) begin
            @(negedge clk);
            t++;
        end
        if_req = 1'b0;
        check("stall_delivered", 32'(pulse_cnt - start), 32'd1);
        if (pulse_cnt == start) exp_q.delete();
        model_fill(pc);
    endtask

    task automatic reset_mid_miss(input logic [31:0] pc);
        prep(pc, 6, 0);
        if_pc  = pc;
        if_req = 1'b1;
        wait_miss_issued();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mem_rn", 32'(mem_rn), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        if_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [23:0] tags [4];
        logic [31:0] pc;
        int          lat;

        tags[0] = 24'h000000;
        tags[1] = 24'h000001;
        tags[2] = 24'hABCDE0;
        tags[3] = 24'h000003;

        mem_img[32'h0000_0004] = 32'h00A0_0093;
        mem_img[32'h0000_0208] = 32'h1234_5678;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;

        rst    = 1'b0;
        rdy    = 1'b1;
        flush  = 1'b0;
        if_req = 1'b0;
        if_pc  = '0;
        repeat (3) @(negedge clk);
        check("reset_if_valid", 32'(if_valid), 32'd0);
        check("reset_if_inst", if_inst, 32'd0);
        check("reset_mem_rn", 32'(mem_rn), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        fetch(32'h0000_0004, 6, 0);           // cold miss
        fetch(32'h0000_0004, 1, 0);           // hit after fill
        fetch(32'h0000_0104, 3, 0);           // conflict on index 1
        fetch(32'h0000_0004, 2, 0);           // evicted, misses again
        fetch(32'h0000_0300, 2, 4);           // stale ready held on entry
        fetch_flushed(32'h0000_0208, 5, 2);   // flush mid-miss
        fetch(32'h0000_0208, 1, 0);           // filled despite flush
        fetch_flushed(32'h0000_0600, 3, 3);   // flush in completion cycle
        fetch(32'h0000_0600, 1, 0);
        idle_flush(32'h0000_0004);
        stall_fetch(32'h0000_040C);
        reset_mid_miss(32'h0000_0500);
        fetch(32'h0000_0004, 2, 0);           // all lines invalid after reset

        for (int n = 0; n < 80; n++) begin
            pc  = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            lat = $urandom_range(1, 5);
            if (!model_hit(pc) && $urandom_range(0, 5) == 0) begin
                fetch_flushed(pc, lat, $urandom_range(0, lat));
            end else begin
                fetch(pc, lat, $urandom_range(0, 2));
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
